// File: rtl/m_dmem_mmio_pkg.sv
// m_dmem_mmio_pkg: shared MMIO offsets, STATUS bit positions and region-select enum.
package m_dmem_mmio_pkg;
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} region_e;
endpackage

// File: rtl/m_tx_fifo.sv
// m_tx_fifo: byte FIFO with registered head; push while full succeeds only alongside a pop.
module m_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [7:0]                 i_wdata,
  input  logic                       i_pop,
  output logic [7:0]                 o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rp];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= (w_push && !w_pop) ? r_cnt + (AW+1)'(1) : (w_pop && !w_push) ? r_cnt - (AW+1)'(1) : r_cnt;
    end
  end
  always_ff @(posedge i_clk)
    if (w_push && !i_reset) r_mem[r_wp] <= i_wdata;
endmodule

// File: rtl/m_dmem_mmio.sv
// m_dmem_mmio: CPU data memory with zero-latency word RAM and MMIO (TX FIFO, STATUS, CYCLE).
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE counter at offset 8.
module m_dmem_mmio
  import m_dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  logic [31:0] r_ram [RAM_WORDS];
  logic [29:0] w_mdelta;
  region_e     w_region;
  logic [3:0]  w_off;
  logic        w_wr_tx, w_wr_st, w_pop, w_full, w_empty, r_ovf;
  logic [FAW:0] w_count;
  logic [31:0] w_status, w_cycle, w_mmio;
  // Word-granular distance from the MMIO base; byte lanes are ignored.
  assign w_mdelta = i_addr[31:2] - MMIO_BASE[31:2];
  always_comb begin
    w_region = ({1'b0, i_addr} < RAM_BYTES) ? RGN_RAM : (w_mdelta < 30'd3) ? RGN_MMIO : RGN_NONE;
    w_off    = {w_mdelta[1:0], 2'b00};
  end
  assign w_wr_tx    = i_we && w_region == RGN_MMIO && w_off == OFF_TXDATA;
  assign w_wr_st    = i_we && w_region == RGN_MMIO && w_off == OFF_STATUS;
  assign w_pop      = o_tx_valid && i_tx_ready;
  assign o_tx_valid = !w_empty;
  m_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_wr_tx),
    .i_wdata (i_wdata[7:0]),
    .i_pop   (i_tx_ready),
    .o_rdata (o_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge i_clk)
    if (i_we && !i_reset && w_region == RGN_RAM) r_ram[i_addr[RAW+1:2]] <= i_wdata;
  // A new overflow outranks a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_ovf <= 1'b0;
    else if (w_wr_tx && w_full && !w_pop) r_ovf <= 1'b1;
    else if (w_wr_st && i_wdata[ST_OVF]) r_ovf <= 1'b0;
  end
`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  logic        w_wr_cyc;
  assign w_wr_cyc = i_we && w_region == RGN_MMIO && w_off == OFF_CYCLE;
  assign w_cycle  = r_cycle;
  // A load counts as this cycle's tick, so the following cycle reads value+1.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_cycle <= '0;
    else r_cycle <= (w_wr_cyc ? i_wdata : r_cycle) + 32'd1;
  end
`else
  assign w_cycle = '0;
`endif
  always_comb begin
    w_status           = '0;
    w_status[31:16]    = 16'(w_count);
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_mmio  = (w_off == OFF_STATUS) ? w_status : (w_off == OFF_CYCLE) ? w_cycle : '0;
    o_rdata = (w_region == RGN_RAM) ? r_ram[i_addr[RAW+1:2]] : (w_region == RGN_MMIO) ? w_mmio : '0;
  end
endmodule
